s2a_wr_arbiter: RTL and testbench

S2A_WR_ARBITER -- requirements
Module: s2a_wr_arbiter

---
 rtl/s2a_wr_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_s2a_wr_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s2a_wr_arbiter.sv
// s2a_wr_arbiter
// Two requesters share one AXI write channel. The block arbitrates round-robin,
// issues a fixed 16-beat burst for the winner, streams the beats out of the
// winner's read buffer (one-cycle read latency), then waits for the B response.
// Only one burst is ever in flight; requests seen outside IDLE simply wait.

module s2a_wr_arbiter #(
    parameter int BURST_LEN = 16
) (
    input  logic        AXI_clk,
    input  logic        rst,

    // requester side
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] waddr0,
    input  logic [31:0] waddr1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,

    // burst buffer read side
    output logic        rd_en,
    output logic [3:0]  rd_addr,
    output logic        rd_sel,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,

    // AXI write address channel
    output logic [31:0] AXI_awaddr,
    output logic [3:0]  AXI_awlen,
    output logic        AXI_awvalid,
    input  logic        AXI_awready,

    // AXI write data channel
    output logic [31:0] AXI_wdata,
    output logic        AXI_wvalid,
    input  logic        AXI_wready,
    output logic        AXI_wlast,

    // AXI write response channel
    input  logic        AXI_bvalid,
    input  logic [1:0]  AXI_bresp,
    output logic        AXI_bready,

    // status
    output logic        err,
    output logic        err_src
);

    localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic        sel_reg, sel_next;          // requester owning the current burst
    logic        last_reg, last_next;        // requester granted most recently
    logic [31:0] awaddr_reg, awaddr_next;
    logic [3:0]  beat_reg, beat_next;        // index of the beat currently on W
    logic        err_reg, err_next;
    logic        err_src_reg, err_src_next;

    // per-requester views of the two port sets
    logic [31:0] waddr_vec [2];
    logic [31:0] wdata_vec [2];
    logic [1:0]  gnt_vec;
    logic [1:0]  done_vec;

    // channel handshakes, qualified by state so stray readies are ignored
    logic        aw_hs;
    logic        w_hs;
    logic        b_hs;
    logic        wlast_int;
    logic        pick;

    assign waddr_vec[0] = waddr0;
    assign waddr_vec[1] = waddr1;
    assign wdata_vec[0] = wdata0;
    assign wdata_vec[1] = wdata1;

    assign aw_hs     = (state_reg == ADDR) && AXI_awready;
    assign w_hs      = (state_reg == DATA) && AXI_wready;
    assign b_hs      = (state_reg == RESP) && AXI_bvalid;
    assign wlast_int = (state_reg == DATA) && (beat_reg == LAST_BEAT);

    // Round-robin choice: a lone request wins; on a tie the requester that was
    // not granted last wins. last_reg resets to 1 so requester 0 takes the
    // first tie.
    assign pick = req1 & (~req0 | ~last_reg);

    // Grant and done pulses are routed to the owner of the burst.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign gnt_vec[gi]  = aw_hs && (sel_reg == 1'(gi));
            assign done_vec[gi] = b_hs && (sel_reg == 1'(gi));
        end
    endgenerate

    assign gnt0  = gnt_vec[0];
    assign gnt1  = gnt_vec[1];
    assign done0 = done_vec[0];
    assign done1 = done_vec[1];

    // The buffer output is forwarded straight onto W; the buffer holds its
    // output while rd_en is low, so a stalled beat stays put.
    assign AXI_wdata  = wdata_vec[sel_reg];
    assign rd_sel     = sel_reg;
    assign AXI_awaddr = awaddr_reg;
    assign AXI_awlen  = LAST_BEAT;
    assign err        = err_reg;
    assign err_src    = err_src_reg;

    // Next-state logic: arbitration in IDLE, then walk the AW, W and B phases.
    always_comb begin
        state_next   = state_reg;
        sel_next     = sel_reg;
        last_next    = last_reg;
        awaddr_next  = awaddr_reg;
        beat_next    = beat_reg;
        err_next     = err_reg;
        err_src_next = err_src_reg;

        case (state_reg)
            IDLE: begin
                if (req0 || req1) begin
                    sel_next    = pick;
                    last_next   = pick;
                    awaddr_next = waddr_vec[pick];
                    state_next  = ADDR;
                end
            end
            ADDR: begin
                if (AXI_awready) begin
                    beat_next  = 4'd0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (AXI_wready) begin
                    // wraps back to 0 after the last beat
                    beat_next = beat_reg + 4'd1;
                    if (beat_reg == LAST_BEAT) begin
                        state_next = RESP;
                    end
                end
            end
            RESP: begin
                if (AXI_bvalid) begin
                    state_next = IDLE;
                    // only the first failing burst is recorded
                    if ((AXI_bresp != 2'b00) && !err_reg) begin
                        err_next     = 1'b1;
                        err_src_next = sel_reg;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Channel outputs and buffer reads decoded from the current state.
    // Beat 0 is prefetched on the AW handshake so it is ready on the first W
    // cycle; every accepted non-final beat then fetches the following one.
    always_comb begin
        AXI_awvalid = (state_reg == ADDR);
        AXI_wvalid  = (state_reg == DATA);
        AXI_wlast   = wlast_int;
        AXI_bready  = (state_reg == RESP);
        rd_en       = 1'b0;
        rd_addr     = 4'd0;

        if (aw_hs) begin
            rd_en   = 1'b1;
            rd_addr = 4'd0;
        end else if (w_hs && !wlast_int) begin
            rd_en   = 1'b1;
            rd_addr = beat_reg + 4'd1;
        end
    end

    // State register; reset abandons any burst and restores the tie-break.
    always_ff @(posedge AXI_clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            sel_reg     <= 1'b0;
            last_reg    <= 1'b1;
            awaddr_reg  <= 32'd0;
            beat_reg    <= 4'd0;
            err_reg     <= 1'b0;
            err_src_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sel_reg     <= sel_next;
            last_reg    <= last_next;
            awaddr_reg  <= awaddr_next;
            beat_reg    <= beat_next;
            err_reg     <= err_next;
            err_src_reg <= err_src_next;
        end
    end

endmodule

// File: tb/tb_s2a_wr_arbiter.sv
// Testbench for s2a_wr_arbiter.
// The stimulus process plays both requesters and the AXI slave; every burst it
// issues is recorded in a table of expected addresses and beat data. A separate
// monitor, sampling on the falling edge, tracks the bus phase from the observed
// handshakes, applies round-robin to the observed requests and checks the DUT
// against the table.

module tb_s2a_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] waddr0 = '0, waddr1 = '0;
    logic        gnt0, gnt1, done0, done1;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic        rd_sel;
    logic [31:0] wdata0, wdata1;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready = 1'b0;
    logic        wlast;
    logic        bvalid = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bready;
    logic        err, err_src;

    always #5 clk = ~clk;

    s2a_wr_arbiter #(.BURST_LEN(16)) dut (
        .AXI_clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .waddr0(waddr0), .waddr1(waddr1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_sel(rd_sel),
        .wdata0(wdata0), .wdata1(wdata1),
        .AXI_awaddr(awaddr), .AXI_awlen(awlen), .AXI_awvalid(awvalid), .AXI_awready(awready),
        .AXI_wdata(wdata), .AXI_wvalid(wvalid), .AXI_wready(wready), .AXI_wlast(wlast),
        .AXI_bvalid(bvalid), .AXI_bresp(bresp), .AXI_bready(bready),
        .err(err), .err_src(err_src)
    );

    // ---------------- buffer model (one-cycle read latency) ----------------
    logic [31:0] mem [2][16];
    always @(posedge clk) begin
        if (rd_en) begin
            wdata0 <= mem[0][rd_addr];
            wdata1 <= mem[1][rd_addr];
        end
    end

    // ---------------- scoreboard tables (written by stimulus) ----------------
    logic [31:0] exp_addr [2][64];
    logic [31:0] exp_data [2][64][16];
    int          issued [2] = '{0, 0};
    int          timeout_cnt = 0;

    // ---------------- counters (written by monitor only) ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / reference model ----------------
    int  m_phase = 0;      // 0 idle, 1 address, 2 data, 3 response
    bit  m_last  = 1'b1;
    bit  m_sel   = 1'b0;
    int  m_idx   = 0;
    int  m_beat  = 0;
    bit  m_err   = 1'b0;
    bit  m_err_src = 1'b0;
    int  cons [2] = '{0, 0};
    int  timeout_seen = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("reset_outputs",
                    64'({awaddr, awvalid, wvalid, wlast, bready, rd_en, rd_addr, rd_sel,
                         gnt0, gnt1, done0, done1, err, err_src}), 64'd0);
                m_phase = 0; m_last = 1'b1; m_err = 1'b0; m_err_src = 1'b0; m_beat = 0;
                cons[0] = issued[0];
                cons[1] = issued[1];
            end else begin
                chk("err_status", 64'({err, err_src}), 64'({m_err, m_err_src}));
                case (m_phase)
                    0: begin
                        chk("idle_quiet", 64'({awvalid, wvalid, bready, rd_en, gnt0, gnt1, done0, done1}), 64'd0);
                        if (req0 || req1) begin
                            if (req0 && req1) m_sel = ~m_last;
                            else              m_sel = req1;
                            m_last  = m_sel;
                            m_idx   = cons[m_sel];
                            m_phase = 1;
                        end
                    end
                    1: begin
                        chk("awvalid", 64'(awvalid), 64'd1);
                        chk("awaddr", 64'(awaddr), 64'(exp_addr[m_sel][m_idx]));
                        chk("awlen", 64'(awlen), 64'd15);
                        chk("rd_sel", 64'(rd_sel), 64'(m_sel));
                        if (awready) begin
                            chk("gnt", 64'({gnt1, gnt0}), m_sel ? 64'd2 : 64'd1);
                            chk("prefetch", 64'({rd_en, rd_addr}), 64'h10);
                            m_phase = 2;
                            m_beat  = 0;
                        end else begin
                            chk("aw_wait", 64'({gnt1, gnt0, rd_en}), 64'd0);
                        end
                    end
                    2: begin
                        chk("data_ctl", 64'({wvalid, bready, awvalid, gnt1, gnt0, done1, done0}), 64'h40);
                        chk("wlast", 64'(wlast), 64'(m_beat == 15));
                        chk("wdata", 64'(wdata), 64'(exp_data[m_sel][m_idx][m_beat]));
                        chk("rd_sel", 64'(rd_sel), 64'(m_sel));
                        if (wready) begin
                            if (m_beat < 15) chk("rd_next", 64'({rd_en, rd_addr}), 64'({1'b1, 4'(m_beat + 1)}));
                            else begin
                                chk("rd_stop", 64'(rd_en), 64'd0);
                                m_phase = 3;
                            end
                            m_beat++;
                        end else begin
                            chk("rd_stall", 64'(rd_en), 64'd0);
                        end
                    end
                    default: begin
                        chk("resp_ctl", 64'({bready, wvalid, wlast, awvalid, rd_en}), 64'h10);
                        chk("rd_sel", 64'(rd_sel), 64'(m_sel));
                        if (bvalid) begin
                            chk("done", 64'({done1, done0}), m_sel ? 64'd2 : 64'd1);
                            if (bresp != 2'b00 && !m_err) begin
                                m_err     = 1'b1;
                                m_err_src = m_sel;
                            end
                            $display("burst req%0d addr=%08h done bresp=%0d", m_sel, exp_addr[m_sel][m_idx], bresp);
                            cons[m_sel]++;
                            m_phase = 0;
                        end else begin
                            chk("no_done", 64'({done1, done0}), 64'd0);
                        end
                    end
                endcase
            end
            if (timeout_cnt != timeout_seen) begin
                chk("timeout", 64'(timeout_cnt), 64'(timeout_seen));
                timeout_seen = timeout_cnt;
            end
        end
    end

    // ---------------- stimulus ----------------
    int          mode = 0;          // 0 random slave, 1 always ready, 2 wready toggling
    int          bresp_force = -1;  // -1 random, else fixed response code
    bit          use_fixed = 1'b0;
    logic [31:0] fixed_addr = 32'hFFFC0040;
    int          quota [2] = '{0, 0};
    int          phase_issued [2] = '{0, 0};
    bit          pend [2] = '{1'b0, 1'b0};
    bit          busy [2] = '{1'b0, 1'b0};
    int          gap [2] = '{0, 0};
    int          done_total = 0;

    task automatic issue(input int n);
        logic [31:0] a;
        a = use_fixed ? fixed_addr : $urandom;
        exp_addr[n][issued[n]] = a;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] d;
            d = $urandom;
            mem[n][i] = d;
            exp_data[n][issued[n]][i] = d;
        end
        issued[n]++;
        phase_issued[n]++;
        pend[n] = 1'b1;
        if (n == 0) begin waddr0 = a; req0 = 1'b1; end
        else        begin waddr1 = a; req1 = 1'b1; end
    endtask

    task automatic step();
        logic [1:0] g, d;
        @(negedge clk);
        g = {gnt1, gnt0};
        d = {done1, done0};
        @(posedge clk);
        #1;
        for (int n = 0; n < 2; n++) begin
            if (pend[n] && g[n]) begin
                pend[n] = 1'b0;
                busy[n] = 1'b1;
                if (n == 0) req0 = 1'b0; else req1 = 1'b0;
            end else if (busy[n] && d[n]) begin
                busy[n] = 1'b0;
                done_total++;
                gap[n] = $urandom_range(0, 4);
            end else if (!pend[n] && !busy[n] && phase_issued[n] < quota[n]) begin
                if (gap[n] > 0) gap[n]--;
                else issue(n);
            end
        end
        case (mode)
            1: begin awready = 1'b1; wready = 1'b1; bvalid = 1'b1; end
            2: begin awready = 1'b1; wready = ~wready; bvalid = 1'b1; end
            default: begin
                awready = ($urandom_range(0, 3) == 0);
                wready  = ($urandom_range(0, 3) != 0);
                bvalid  = ($urandom_range(0, 2) == 0);
            end
        endcase
        if (bresp_force >= 0)              bresp = 2'(bresp_force);
        else if (mode == 1)                bresp = 2'b00;
        else if ($urandom_range(0, 5) == 0) bresp = 2'($urandom_range(1, 3));
        else                               bresp = 2'b00;
    endtask

    task automatic run(input int q0, input int q1, input int max_cycles, input int stop_beat);
        int cyc;
        int start;
        cyc = 0;
        start = done_total;
        quota[0] = q0; quota[1] = q1;
        phase_issued[0] = 0; phase_issued[1] = 0;
        while ((done_total - start) < (q0 + q1) && cyc < max_cycles) begin
            if (stop_beat >= 0 && m_phase == 2 && m_beat == stop_beat) break;
            step();
            cyc++;
        end
        if (cyc >= max_cycles) begin
            timeout_cnt++;
            $display("phase ended by cycle limit after %0d cycles", cyc);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // single burst from requester 0, slave always ready, fixed address
        mode = 1; use_fixed = 1'b1;
        run(1, 0, 200, -1);
        use_fixed = 1'b0;

        // both requesters busy, random slave behaviour and responses
        mode = 0;
        run(12, 12, 4000, -1);

        // wready toggling every cycle
        mode = 2;
        run(3, 3, 1000, -1);

        // reset in the middle of a requester-1 burst, after beat 7
        mode = 1;
        run(0, 1, 200, 7);
        #2 rst = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        busy[0] = 1'b0; busy[1] = 1'b0;
        gap[0] = 0; gap[1] = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        run(0, 1, 200, -1);

        // first error from requester 1, second from requester 0
        bresp_force = 2;
        run(0, 1, 200, -1);
        bresp_force = 3;
        run(1, 0, 200, -1);
        bresp_force = -1;

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
